// File: rtl/tl_slave_mem_beh_if.sv
// TileLink A/D channel bundle between a tile master and the behavioural slave memory.
// The master modport drives requests and D acceptance; the slave modport answers.
interface tl_slave_mem_beh_if #(
   parameter int SRC_SIZE  = 2,
   parameter int SINK_SIZE = 2,
   parameter int BUS_SIZE  = 8,
   parameter int ADR_WIDTH = 32
);
   logic                   a_ready;
   logic                   a_valid;
   logic [2:0]             a_bits_opcode;
   logic [2:0]             a_bits_param;
   logic [3:0]             a_bits_size;
   logic [SRC_SIZE-1:0]    a_bits_source;
   logic [ADR_WIDTH-1:0]   a_bits_address;
   logic [BUS_SIZE-1:0]    a_bits_mask;
   logic [8*BUS_SIZE-1:0]  a_bits_data;

   logic                   d_ready;
   logic                   d_valid;
   logic [2:0]             d_bits_opcode;
   logic [1:0]             d_bits_param;
   logic [3:0]             d_bits_size;
   logic [SRC_SIZE-1:0]    d_bits_source;
   logic [SINK_SIZE-1:0]   d_bits_sink;
   logic                   d_bits_denied;
   logic [8*BUS_SIZE-1:0]  d_bits_data;
   logic                   d_bits_corrupt;

   modport master (
      input  a_ready,
      output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
             a_bits_address, a_bits_mask, a_bits_data,
      output d_ready,
      input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
             d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
   );

   modport slave (
      output a_ready,
      input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
             a_bits_address, a_bits_mask, a_bits_data,
      input  d_ready,
      output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
             d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
   );
endinterface

// File: rtl/tl_slave_mem_beh.sv
// Behavioural TileLink slave memory: single-beat Get/Put/Hint served from a word array,
// in-order D responses with a programmable minimum latency and a bounded response queue.
module tl_slave_mem_beh #(
   parameter int                   SRC_SIZE  = 2,
   parameter int                   SINK_SIZE = 2,
   parameter int                   BUS_SIZE  = 8,
   parameter int                   ADR_WIDTH = 32,
   parameter logic [ADR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                   MEM_WORDS = 1024,
   parameter int                   RSP_DEPTH = 4,
   parameter int                   LATENCY   = 2
) (
   input logic             clock,
   input logic             reset,
   tl_slave_mem_beh_if.slave tl
);
   localparam int LOG_BUS = $clog2(BUS_SIZE);
   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int PTR_W   = $clog2(RSP_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int DW      = 8 * BUS_SIZE;
   localparam logic [ADR_WIDTH-1:0] SPAN = ADR_WIDTH'(MEM_WORDS * BUS_SIZE);
   localparam logic [ADR_WIDTH-1:0] ONES = '1;
   localparam logic [7:0]           LAT  = 8'(LATENCY);

   typedef enum logic [2:0] {
      A_PUT_FULL    = 3'd0,
      A_PUT_PARTIAL = 3'd1,
      A_GET         = 3'd4,
      A_HINT        = 3'd5
   } a_op_e;

   typedef enum logic [2:0] {
      D_ACCESS_ACK      = 3'd0,
      D_ACCESS_ACK_DATA = 3'd1,
      D_HINT_ACK        = 3'd2
   } d_op_e;

   typedef struct packed {
      d_op_e               opcode;
      logic [3:0]          size;
      logic [SRC_SIZE-1:0] source;
      logic                denied;
      logic                corrupt;
      logic [DW-1:0]       data;
      logic [7:0]          ts;
   } rsp_t;

   logic [DW-1:0]        mem [MEM_WORDS];
   rsp_t                 q   [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] vis;
   logic [PTR_W-1:0]     head, tail;
   logic [CNT_W-1:0]     count;
   logic [7:0]           tcnt;

   logic [ADR_WIDTH-1:0] offset, align_mask;
   logic [IDX_W-1:0]     idx;
   logic                 legal, fire, deq, do_write, head_vis;
   logic [7:0]           head_age;
   rsp_t                 new_rsp;
   rsp_t                 head_rsp;

   // Range check through the offset so BASE_ADDR + span never has to fit the address width.
   assign offset     = tl.a_bits_address - BASE_ADDR;
   assign align_mask = ~(ONES << tl.a_bits_size);
   assign legal      = (tl.a_bits_size <= 4'(LOG_BUS))
                    && ((tl.a_bits_address & align_mask) == '0)
                    && (tl.a_bits_address >= BASE_ADDR)
                    && (offset < SPAN);
   assign idx        = offset[LOG_BUS +: IDX_W];

   assign tl.a_ready = !reset && (count < CNT_W'(RSP_DEPTH));
   assign fire       = tl.a_valid && tl.a_ready;

   always_comb begin
      new_rsp        = '0;
      do_write       = 1'b0;
      new_rsp.opcode = D_ACCESS_ACK;
      new_rsp.size   = tl.a_bits_size;
      new_rsp.source = tl.a_bits_source;
      new_rsp.ts     = tcnt + 8'd1;
      case (tl.a_bits_opcode)
         A_GET: begin
            new_rsp.opcode  = D_ACCESS_ACK_DATA;
            new_rsp.denied  = !legal;
            new_rsp.corrupt = !legal;
            new_rsp.data    = legal ? mem[idx] : '0;
         end
         A_PUT_FULL, A_PUT_PARTIAL: begin
            new_rsp.denied = !legal;
            do_write       = legal;
         end
         A_HINT: begin
            new_rsp.opcode = D_HINT_ACK;
            new_rsp.denied = !legal;
         end
         default: new_rsp.denied = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (fire && do_write) begin
         for (int unsigned b = 0; b < BUS_SIZE; b++) begin
            if (tl.a_bits_mask[b]) mem[idx][8*b +: 8] <= tl.a_bits_data[8*b +: 8];
         end
      end
   end

   // Sticky visibility: once an entry has aged past LATENCY it stays visible across tcnt wrap.
   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
         if ((tcnt - q[PTR_W'(i)].ts) >= LAT) vis[PTR_W'(i)] <= 1'b1;
      end
      if (fire) begin
         q[tail]   <= new_rsp;
         vis[tail] <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
         tcnt  <= '0;
      end else begin
         tcnt <= tcnt + 8'd1;
         if (fire) tail <= tail + PTR_W'(1);
         if (deq)  head <= head + PTR_W'(1);
         case ({fire, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_rsp   = q[head];
   assign head_age   = tcnt - head_rsp.ts;
   assign head_vis   = vis[head] || (head_age >= LAT);
   assign tl.d_valid = (count != '0) && head_vis;
   assign deq        = tl.d_valid && tl.d_ready;

   always_comb begin
      tl.d_bits_opcode  = '0;
      tl.d_bits_param   = '0;
      tl.d_bits_size    = '0;
      tl.d_bits_source  = '0;
      tl.d_bits_sink    = '0;
      tl.d_bits_denied  = 1'b0;
      tl.d_bits_data    = '0;
      tl.d_bits_corrupt = 1'b0;
      if (tl.d_valid) begin
         tl.d_bits_opcode  = head_rsp.opcode;
         tl.d_bits_size    = head_rsp.size;
         tl.d_bits_source  = head_rsp.source;
         tl.d_bits_denied  = head_rsp.denied;
         tl.d_bits_data    = head_rsp.data;
         tl.d_bits_corrupt = head_rsp.corrupt;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{tl.a_bits_param, offset};
endmodule

// File: tb/tb_tl_slave_mem_beh.sv
// Directed, table-driven bench for tl_slave_mem_beh: access vectors, latency, backpressure,
// sticky visibility across timestamp wrap, and reset with responses in flight.
module tb_tl_slave_mem_beh;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   fire_cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   tl_slave_mem_beh_if #(.SRC_SIZE(2), .SINK_SIZE(2), .BUS_SIZE(8), .ADR_WIDTH(32)) tl ();
   tl_slave_mem_beh_if #(.SRC_SIZE(2), .SINK_SIZE(2), .BUS_SIZE(8), .ADR_WIDTH(32)) tl5 ();

   tl_slave_mem_beh #(.SRC_SIZE(2), .SINK_SIZE(2), .BUS_SIZE(8), .ADR_WIDTH(32),
      .BASE_ADDR(32'h8000_0000), .MEM_WORDS(1024), .RSP_DEPTH(4), .LATENCY(2))
      dut (.clock(clock), .reset(reset), .tl(tl));

   tl_slave_mem_beh #(.SRC_SIZE(2), .SINK_SIZE(2), .BUS_SIZE(8), .ADR_WIDTH(32),
      .BASE_ADDR(32'h8000_0000), .MEM_WORDS(1024), .RSP_DEPTH(4), .LATENCY(5))
      dut5 (.clock(clock), .reset(reset), .tl(tl5));

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  size;
      logic [1:0]  src;
      logic [31:0] addr;
      logic [7:0]  mask;
      logic [63:0] data;
      logic [2:0]  e_op;
      logic        e_den;
      logic        e_cor;
      logic [63:0] e_data;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                               input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                               input logic [2:0] e_op, input logic e_den, input logic e_cor,
                               input logic [63:0] e_data);
      vec_t v;
      v.op = op; v.size = size; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
      v.e_op = e_op; v.e_den = e_den; v.e_cor = e_cor; v.e_data = e_data;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic a_send(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                         input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
      int n;
      tl.a_bits_opcode  = op;
      tl.a_bits_size    = size;
      tl.a_bits_source  = src;
      tl.a_bits_address = addr;
      tl.a_bits_mask    = mask;
      tl.a_bits_data    = data;
      tl.a_valid        = 1'b1;
      n = 0;
      while (!tl.a_ready && n < 50) begin
         @(posedge clock); #1; n++;
      end
      check("a_ready_wait", 64'(tl.a_ready), 64'd1);
      @(posedge clock); #1;
      fire_cyc   = cyc;
      tl.a_valid = 1'b0;
   endtask

   task automatic d_wait(input int limit);
      int n;
      n = 0;
      while (!tl.d_valid && n < limit) begin
         @(posedge clock); #1; n++;
      end
      check("d_valid_wait", 64'(tl.d_valid), 64'd1);
   endtask

   task automatic d_take();
      tl.d_ready = 1'b1;
      @(posedge clock); #1;
      tl.d_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] f_addr [5];
      logic [63:0] f_data [5];
      logic [1:0]  f_src  [5];
      int got, bad, n;
      logic pend_fire, fired5;

      tl.a_valid = 1'b0; tl.a_bits_opcode = '0; tl.a_bits_param = '0; tl.a_bits_size = '0;
      tl.a_bits_source = '0; tl.a_bits_address = '0; tl.a_bits_mask = '0; tl.a_bits_data = '0;
      tl.d_ready = 1'b0;
      tl5.a_valid = 1'b0; tl5.a_bits_opcode = '0; tl5.a_bits_param = '0; tl5.a_bits_size = '0;
      tl5.a_bits_source = '0; tl5.a_bits_address = '0; tl5.a_bits_mask = '0; tl5.a_bits_data = '0;
      tl5.d_ready = 1'b0;

      vecs[0]  = mk(3'd0, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h1122334455667788, 3'd0, 0, 0, 64'h0);
      vecs[1]  = mk(3'd4, 4'd3, 2'd2, 32'h8000_0010, 8'hFF, 64'h0,                3'd1, 0, 0, 64'h1122334455667788);
      vecs[2]  = mk(3'd1, 4'd3, 2'd3, 32'h8000_0010, 8'h0F, 64'hAAAAAAAABBBBBBBB, 3'd0, 0, 0, 64'h0);
      vecs[3]  = mk(3'd4, 4'd3, 2'd0, 32'h8000_0010, 8'h00, 64'h0,                3'd1, 0, 0, 64'h11223344BBBBBBBB);
      vecs[4]  = mk(3'd4, 4'd3, 2'd1, 32'h7FFF_FFF8, 8'hFF, 64'h0,                3'd1, 1, 1, 64'h0);
      vecs[5]  = mk(3'd4, 4'd3, 2'd2, 32'h8000_0004, 8'hFF, 64'h0,                3'd1, 1, 1, 64'h0);
      vecs[6]  = mk(3'd2, 4'd3, 2'd3, 32'h8000_0010, 8'hFF, 64'h0,                3'd0, 1, 0, 64'h0);
      vecs[7]  = mk(3'd5, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'h0,                3'd2, 0, 0, 64'h0);
      vecs[8]  = mk(3'd5, 4'd3, 2'd1, 32'h7FFF_FFF8, 8'hFF, 64'h0,                3'd2, 1, 0, 64'h0);
      vecs[9]  = mk(3'd0, 4'd4, 2'd2, 32'h8000_0010, 8'hFF, 64'hDEADBEEFDEADBEEF, 3'd0, 1, 0, 64'h0);
      vecs[10] = mk(3'd4, 4'd3, 2'd3, 32'h8000_0010, 8'hFF, 64'h0,                3'd1, 0, 0, 64'h11223344BBBBBBBB);
      vecs[11] = mk(3'd0, 4'd3, 2'd0, 32'h8000_1FF8, 8'hFF, 64'hCAFEF00D12345678, 3'd0, 0, 0, 64'h0);
      vecs[12] = mk(3'd4, 4'd3, 2'd1, 32'h8000_1FF8, 8'hFF, 64'h0,                3'd1, 0, 0, 64'hCAFEF00D12345678);
      vecs[13] = mk(3'd4, 4'd3, 2'd2, 32'h8000_2000, 8'hFF, 64'h0,                3'd1, 1, 1, 64'h0);
      vecs[14] = mk(3'd1, 4'd2, 2'd3, 32'h8000_0014, 8'hF0, 64'h9988776600000000, 3'd0, 0, 0, 64'h0);
      vecs[15] = mk(3'd4, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'h0,                3'd1, 0, 0, 64'h99887766BBBBBBBB);
      vecs[16] = mk(3'd7, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h0,                3'd0, 1, 0, 64'h0);
      vecs[17] = mk(3'd4, 4'd2, 2'd2, 32'h8000_0012, 8'hFF, 64'h0,                3'd1, 1, 1, 64'h0);
      vecs[18] = mk(3'd4, 4'd0, 2'd3, 32'h8000_0013, 8'h00, 64'h0,                3'd1, 0, 0, 64'h99887766BBBBBBBB);

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_a_ready", 64'(tl.a_ready), 64'd0);
      check("rst_d_valid", 64'(tl.d_valid), 64'd0);
      check("rst_d_data", tl.d_bits_data, 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      check("post_rst_a_ready", 64'(tl.a_ready), 64'd1);
      check("post_rst_d_valid", 64'(tl.d_valid), 64'd0);

      // Table vectors
      for (int i = 0; i < NV; i++) begin
         a_send(vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr, vecs[i].mask, vecs[i].data);
         d_wait(20);
         check($sformatf("v%0d_opcode", i), 64'(tl.d_bits_opcode), 64'(vecs[i].e_op));
         check($sformatf("v%0d_denied", i), 64'(tl.d_bits_denied), 64'(vecs[i].e_den));
         check($sformatf("v%0d_corrupt", i), 64'(tl.d_bits_corrupt), 64'(vecs[i].e_cor));
         check($sformatf("v%0d_data", i), tl.d_bits_data, vecs[i].e_data);
         check($sformatf("v%0d_source", i), 64'(tl.d_bits_source), 64'(vecs[i].src));
         check($sformatf("v%0d_size", i), 64'(tl.d_bits_size), 64'(vecs[i].size));
         check($sformatf("v%0d_param", i), 64'(tl.d_bits_param), 64'd0);
         check($sformatf("v%0d_sink", i), 64'(tl.d_bits_sink), 64'd0);
         d_take();
      end
      check("empty_d_valid", 64'(tl.d_valid), 64'd0);
      check("empty_d_data", tl.d_bits_data, 64'd0);
      check("empty_d_opcode", 64'(tl.d_bits_opcode), 64'd0);

      // Latency 2 with d_ready held high
      tl.d_ready = 1'b1;
      a_send(3'd4, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h0);
      check("lat2_not_early", 64'(tl.d_valid), 64'd0);
      n = 0;
      while (!tl.d_valid && n < 20) begin
         @(posedge clock); #1; n++;
      end
      check("lat2_cycles", 64'(cyc - fire_cyc), 64'd2);
      @(posedge clock); #1;
      tl.d_ready = 1'b0;
      check("lat2_dequeued", 64'(tl.d_valid), 64'd0);

      // Latency 5 on the second instance
      tl5.d_ready = 1'b1;
      tl5.a_bits_opcode = 3'd4; tl5.a_bits_size = 4'd3; tl5.a_bits_source = 2'd2;
      tl5.a_bits_address = 32'h8000_0000; tl5.a_bits_mask = 8'hFF;
      check("lat5_a_ready", 64'(tl5.a_ready), 64'd1);
      tl5.a_valid = 1'b1;
      @(posedge clock); #1;
      fire_cyc = cyc;
      tl5.a_valid = 1'b0;
      n = 0;
      while (!tl5.d_valid && n < 20) begin
         @(posedge clock); #1; n++;
      end
      check("lat5_cycles", 64'(cyc - fire_cyc), 64'd5);
      check("lat5_source", 64'(tl5.d_bits_source), 64'd2);
      @(posedge clock); #1;
      tl5.d_ready = 1'b0;

      // Head stays visible and stable across a timestamp wrap
      a_send(3'd4, 4'd3, 2'd1, 32'h8000_1FF8, 8'hFF, 64'h0);
      d_wait(10);
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clock); #1;
         if (!tl.d_valid || tl.d_bits_data !== 64'hCAFEF00D12345678 || tl.d_bits_source !== 2'd1) bad++;
      end
      check("sticky_hold_bad_cycles", 64'(bad), 64'd0);
      d_take();

      // Backpressure: four queued, fifth stalls until a dequeue
      f_addr[0] = 32'h8000_0010; f_data[0] = 64'h99887766BBBBBBBB; f_src[0] = 2'd0;
      f_addr[1] = 32'h8000_1FF8; f_data[1] = 64'hCAFEF00D12345678; f_src[1] = 2'd1;
      f_addr[2] = 32'h8000_0010; f_data[2] = 64'h99887766BBBBBBBB; f_src[2] = 2'd2;
      f_addr[3] = 32'h8000_1FF8; f_data[3] = 64'hCAFEF00D12345678; f_src[3] = 2'd3;
      f_addr[4] = 32'h8000_0010; f_data[4] = 64'h99887766BBBBBBBB; f_src[4] = 2'd0;
      tl.d_ready = 1'b0;
      tl.a_bits_opcode = 3'd4; tl.a_bits_size = 4'd3; tl.a_bits_mask = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         tl.a_bits_address = f_addr[k];
         tl.a_bits_source  = f_src[k];
         tl.a_valid        = 1'b1;
         check($sformatf("full_a_ready_%0d", k), 64'(tl.a_ready), 64'd1);
         @(posedge clock); #1;
      end
      tl.a_bits_address = f_addr[4];
      tl.a_bits_source  = f_src[4];
      check("full_a_ready_low", 64'(tl.a_ready), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      check("full_a_ready_still_low", 64'(tl.a_ready), 64'd0);
      tl.d_ready = 1'b1;
      got = 0;
      fired5 = 1'b0;
      for (int c = 0; c < 40 && got < 5; c++) begin
         if (tl.d_valid) begin
            check($sformatf("full_src_%0d", got), 64'(tl.d_bits_source), 64'(f_src[got]));
            check($sformatf("full_data_%0d", got), tl.d_bits_data, f_data[got]);
            got++;
         end
         pend_fire = tl.a_valid && tl.a_ready;
         @(posedge clock); #1;
         if (pend_fire) begin
            tl.a_valid = 1'b0;
            fired5 = 1'b1;
         end
      end
      check("full_resp_count", 64'(got), 64'd5);
      check("full_fifth_accepted", 64'(fired5), 64'd1);
      tl.d_ready = 1'b0;

      // Reset with three responses queued; array contents must survive
      a_send(3'd4, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h0);
      a_send(3'd4, 4'd3, 2'd2, 32'h8000_0010, 8'hFF, 64'h0);
      a_send(3'd4, 4'd3, 2'd3, 32'h8000_1FF8, 8'hFF, 64'h0);
      d_wait(10);
      reset = 1'b1;
      #1;
      check("rst_flight_d_valid", 64'(tl.d_valid), 64'd0);
      check("rst_flight_a_ready", 64'(tl.a_ready), 64'd0);
      check("rst_flight_d_data", tl.d_bits_data, 64'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("rst_release_a_ready", 64'(tl.a_ready), 64'd1);
      check("rst_release_d_valid", 64'(tl.d_valid), 64'd0);
      @(posedge clock); #1;
      a_send(3'd4, 4'd3, 2'd2, 32'h8000_0010, 8'hFF, 64'h0);
      d_wait(10);
      check("persist_data_10", tl.d_bits_data, 64'h99887766BBBBBBBB);
      check("persist_src_10", 64'(tl.d_bits_source), 64'd2);
      d_take();
      a_send(3'd4, 4'd3, 2'd3, 32'h8000_1FF8, 8'hFF, 64'h0);
      d_wait(10);
      check("persist_data_1ff8", tl.d_bits_data, 64'hCAFEF00D12345678);
      d_take();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
